// File: rtl/usb_buf_pkg.sv
// rtl/usb_buf_pkg.sv - shared state encoding, depth and AHB size helpers for the USB endpoint buffer
package usb_buf_pkg;

    localparam int BUF_DEPTH = 64;

    localparam logic [1:0] AHB_SIZE_BYTE = 2'b00;
    localparam logic [1:0] AHB_SIZE_HALF = 2'b01;
    localparam logic [1:0] AHB_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_USB_WR  = 3'd1,
        ST_USB_RD  = 3'd2,
        ST_USB_CAP = 3'd3,
        ST_AHB_WR  = 3'd4,
        ST_AHB_RD  = 3'd5,
        ST_AHB_CAP = 3'd6
    } buf_state_e;

    // The reserved encoding 11 moves a full word, same as 10.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            AHB_SIZE_BYTE: return 3'd1;
            AHB_SIZE_HALF: return 3'd2;
            AHB_SIZE_WORD: return 3'd4;
            default:       return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/buffer_pointer_unit.sv
// rtl/buffer_pointer_unit.sv - write/read pointers and occupancy count for the endpoint buffer
module buffer_pointer_unit
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       inc_w,
    input  logic                       inc_r,
    output logic [$clog2(DEPTH)-1:0]   wptr,
    output logic [$clog2(DEPTH)-1:0]   rptr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d;

    // The sequencer never writes and reads in the same cycle, so the
    // occupancy update below never needs to net an increment against a decrement.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (inc_w) begin
                wptr_d = wptr_q + AW'(1);
                occ_d  = occ_q + (AW+1)'(1);
            end
            if (inc_r) begin
                rptr_d = rptr_q + AW'(1);
                occ_d  = occ_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    assign wptr      = wptr_q;
    assign rptr      = rptr_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/data_buffer_arbiter.sv
// rtl/data_buffer_arbiter.sv - USB/AHB sequencer for the shared endpoint SRAM; BUFFER_ARB_RR_EN alternates side priority
module data_buffer_arbiter
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       usb_wr_req,
    input  logic [7:0]                 usb_wr_data,
    input  logic                       usb_rd_req,
    input  logic                       ahb_wr_req,
    input  logic                       ahb_rd_req,
    input  logic [1:0]                 ahb_size,
    input  logic [31:0]                ahb_wr_data,
    input  logic [7:0]                 mem_rdata,
    output logic                       usb_wr_ack,
    output logic                       usb_rd_ack,
    output logic                       ahb_wr_ack,
    output logic                       ahb_rd_ack,
    output logic                       usb_err,
    output logic                       ahb_err,
    output logic [7:0]                 usb_rd_data,
    output logic [31:0]                ahb_rd_data,
    output logic [$clog2(DEPTH):0]     buffer_occupancy,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic                       mem_wen,
    output logic                       mem_ren,
    output logic [7:0]                 mem_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_EXT = (AW+2)'(DEPTH);

    buf_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [2:0]    nbytes_q, nbytes_d;
    logic          usb_wr_ack_q, usb_wr_ack_d, usb_rd_ack_q, usb_rd_ack_d;
    logic          ahb_wr_ack_q, ahb_wr_ack_d, ahb_rd_ack_q, ahb_rd_ack_d;
    logic          usb_err_q, usb_err_d, ahb_err_q, ahb_err_d;
    logic          busy_q, busy_d;
    logic [7:0]    usb_rd_data_q, usb_rd_data_d;
    logic [31:0]   ahb_rd_data_q, ahb_rd_data_d;

    logic          inc_w, inc_r;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   occ;

    logic          uw, ur, aw, ar, usb_side, ahb_side, pick_ahb;
    logic [2:0]    n_req, nm1;
    logic [1:0]    cap_idx;
    logic          last_byte;
    logic [AW+1:0] occ_ext, n_ext;

    buffer_pointer_unit #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .inc_w     (inc_w),
        .inc_r     (inc_r),
        .wptr      (wptr),
        .rptr      (rptr),
        .occupancy (occ)
    );

    // A requester still holds req during its ack cycle, so it is masked there.
    assign uw       = usb_wr_req & ~usb_wr_ack_q;
    assign ur       = usb_rd_req & ~usb_rd_ack_q;
    assign aw       = ahb_wr_req & ~ahb_wr_ack_q;
    assign ar       = ahb_rd_req & ~ahb_rd_ack_q;
    assign usb_side = uw | ur;
    assign ahb_side = aw | ar;

`ifdef BUFFER_ARB_RR_EN
    logic last_usb_q, last_usb_d;

    assign pick_ahb = ahb_side & (~usb_side | last_usb_q);

    // Only a contested decision moves the flag; an uncontested grant leaves it.
    always_comb begin
        last_usb_d = last_usb_q;
        if (state_q == ST_IDLE && usb_side && ahb_side && !clear) begin
            last_usb_d = ~pick_ahb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) last_usb_q <= 1'b0;
        else     last_usb_q <= last_usb_d;
    end
`else
    assign pick_ahb = ahb_side & ~usb_side;
`endif

    assign n_req     = size_to_bytes(ahb_size);
    assign occ_ext   = {1'b0, occ};
    assign n_ext     = (AW+2)'(n_req);
    assign nm1       = nbytes_q - 3'd1;
    assign last_byte = ({1'b0, cnt_q} == nm1);
    assign cap_idx   = (state_q == ST_AHB_CAP) ? nm1[1:0] : cnt_q - 2'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nbytes_d      = nbytes_q;
        usb_wr_ack_d  = 1'b0;
        usb_rd_ack_d  = 1'b0;
        ahb_wr_ack_d  = 1'b0;
        ahb_rd_ack_d  = 1'b0;
        usb_err_d     = 1'b0;
        ahb_err_d     = 1'b0;
        usb_rd_data_d = usb_rd_data_q;
        ahb_rd_data_d = ahb_rd_data_q;
        inc_w         = 1'b0;
        inc_r         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_ahb) begin
                    nbytes_d = n_req;
                    cnt_d    = 2'd0;
                    if (aw) begin
                        if (occ_ext + n_ext <= DEPTH_EXT) state_d = ST_AHB_WR;
                        else begin ahb_wr_ack_d = 1'b1; ahb_err_d = 1'b1; end
                    end else begin
                        ahb_rd_data_d = '0;
                        if (occ_ext >= n_ext) state_d = ST_AHB_RD;
                        else begin ahb_rd_ack_d = 1'b1; ahb_err_d = 1'b1; end
                    end
                end else if (usb_side) begin
                    if (uw) begin
                        if (occ_ext < DEPTH_EXT) state_d = ST_USB_WR;
                        else begin usb_wr_ack_d = 1'b1; usb_err_d = 1'b1; end
                    end else begin
                        if (occ != '0) state_d = ST_USB_RD;
                        else begin usb_rd_ack_d = 1'b1; usb_err_d = 1'b1; end
                    end
                end
            end
            ST_USB_WR: begin
                inc_w        = 1'b1;
                usb_wr_ack_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_USB_RD: begin
                inc_r   = 1'b1;
                state_d = ST_USB_CAP;
            end
            ST_USB_CAP: begin
                usb_rd_data_d = mem_rdata;
                usb_rd_ack_d  = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_AHB_WR: begin
                inc_w = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (last_byte) begin
                    ahb_wr_ack_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_AHB_RD: begin
                // mem_rdata here belongs to the fetch issued one cycle earlier.
                inc_r = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q != 2'd0) ahb_rd_data_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
                if (last_byte) state_d = ST_AHB_CAP;
            end
            ST_AHB_CAP: begin
                ahb_rd_data_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
                ahb_rd_ack_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d      = ST_IDLE;
            cnt_d        = 2'd0;
            usb_wr_ack_d = 1'b0;
            usb_rd_ack_d = 1'b0;
            ahb_wr_ack_d = 1'b0;
            ahb_rd_ack_d = 1'b0;
            usb_err_d    = 1'b0;
            ahb_err_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            nbytes_q      <= '0;
            usb_wr_ack_q  <= 1'b0;
            usb_rd_ack_q  <= 1'b0;
            ahb_wr_ack_q  <= 1'b0;
            ahb_rd_ack_q  <= 1'b0;
            usb_err_q     <= 1'b0;
            ahb_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            usb_rd_data_q <= '0;
            ahb_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nbytes_q      <= nbytes_d;
            usb_wr_ack_q  <= usb_wr_ack_d;
            usb_rd_ack_q  <= usb_rd_ack_d;
            ahb_wr_ack_q  <= ahb_wr_ack_d;
            ahb_rd_ack_q  <= ahb_rd_ack_d;
            usb_err_q     <= usb_err_d;
            ahb_err_q     <= ahb_err_d;
            busy_q        <= busy_d;
            usb_rd_data_q <= usb_rd_data_d;
            ahb_rd_data_q <= ahb_rd_data_d;
        end
    end

    assign mem_wen  = (state_q == ST_USB_WR) || (state_q == ST_AHB_WR);
    assign mem_ren  = (state_q == ST_USB_RD) || (state_q == ST_AHB_RD);
    assign mem_addr = mem_wen ? wptr : rptr;

    always_comb begin
        mem_wdata = 8'h00;
        if (state_q == ST_USB_WR)      mem_wdata = usb_wr_data;
        else if (state_q == ST_AHB_WR) mem_wdata = ahb_wr_data[{cnt_q, 3'b000} +: 8];
    end

    assign usb_wr_ack       = usb_wr_ack_q;
    assign usb_rd_ack       = usb_rd_ack_q;
    assign ahb_wr_ack       = ahb_wr_ack_q;
    assign ahb_rd_ack       = ahb_rd_ack_q;
    assign usb_err          = usb_err_q;
    assign ahb_err          = ahb_err_q;
    assign usb_rd_data      = usb_rd_data_q;
    assign ahb_rd_data      = ahb_rd_data_q;
    assign buffer_occupancy = occ;
    assign busy             = busy_q;

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// tb/tb_data_buffer_arbiter.sv - self-checking bench for data_buffer_arbiter with an SRAM model and FIFO reference
module tb_data_buffer_arbiter;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        usb_wr_req;
    logic [7:0]  usb_wr_data;
    logic        usb_rd_req;
    logic        ahb_wr_req;
    logic        ahb_rd_req;
    logic [1:0]  ahb_size;
    logic [31:0] ahb_wr_data;
    logic [7:0]  mem_rdata;
    logic        usb_wr_ack, usb_rd_ack, ahb_wr_ack, ahb_rd_ack;
    logic        usb_err, ahb_err;
    logic [7:0]  usb_rd_data;
    logic [31:0] ahb_rd_data;
    logic [6:0]  buffer_occupancy;
    logic        busy;
    logic [5:0]  mem_addr;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_wdata;

    data_buffer_arbiter #(.DEPTH(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .usb_wr_req       (usb_wr_req),
        .usb_wr_data      (usb_wr_data),
        .usb_rd_req       (usb_rd_req),
        .ahb_wr_req       (ahb_wr_req),
        .ahb_rd_req       (ahb_rd_req),
        .ahb_size         (ahb_size),
        .ahb_wr_data      (ahb_wr_data),
        .mem_rdata        (mem_rdata),
        .usb_wr_ack       (usb_wr_ack),
        .usb_rd_ack       (usb_rd_ack),
        .ahb_wr_ack       (ahb_wr_ack),
        .ahb_rd_ack       (ahb_rd_ack),
        .usb_err          (usb_err),
        .ahb_err          (ahb_err),
        .usb_rd_data      (usb_rd_data),
        .ahb_rd_data      (ahb_rd_data),
        .buffer_occupancy (buffer_occupancy),
        .busy             (busy),
        .mem_addr         (mem_addr),
        .mem_wen          (mem_wen),
        .mem_ren          (mem_ren),
        .mem_wdata        (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sram [64];
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_q [$];

    typedef struct {
        int          kind;     // 0 usb_wr, 1 usb_rd, 2 ahb_wr, 3 ahb_rd
        logic [1:0]  sz;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [6:0]  exp_occ;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sz_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int exp_lat(input int kind, input int n, input logic err);
        if (err) return 1;
        case (kind)
            0: return 2;
            1: return 3;
            2: return n + 1;
            default: return n + 2;
        endcase
    endfunction

    task automatic run_txn(input int kind, input logic [1:0] sz, input logic [31:0] wd,
                           output int lat, output logic err, output logic [31:0] rd,
                           output logic [6:0] occ);
        logic hit;
        lat = -1; err = 1'b0; rd = '0; occ = buffer_occupancy;
        @(posedge clk); #1;
        case (kind)
            0: begin usb_wr_data = wd[7:0]; usb_wr_req = 1'b1; end
            1: usb_rd_req = 1'b1;
            2: begin ahb_size = sz; ahb_wr_data = wd; ahb_wr_req = 1'b1; end
            default: begin ahb_size = sz; ahb_rd_req = 1'b1; end
        endcase
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(negedge clk);
            case (kind)
                0: hit = usb_wr_ack;
                1: hit = usb_rd_ack;
                2: hit = ahb_wr_ack;
                default: hit = ahb_rd_ack;
            endcase
            if (hit) begin
                lat = k;
                err = (kind < 2) ? usb_err : ahb_err;
                rd  = (kind == 1) ? {24'h0, usb_rd_data} : ahb_rd_data;
                occ = buffer_occupancy;
            end
        end
        @(posedge clk); #1;
        usb_wr_req = 1'b0; usb_rd_req = 1'b0; ahb_wr_req = 1'b0; ahb_rd_req = 1'b0;
    endtask

    // Expected behaviour from a byte FIFO: space/data check, then push/pop n bytes.
    task automatic model_txn(input int kind, input logic [1:0] sz, input logic [31:0] wd, input string tag);
        int n, lat;
        logic e, err;
        logic [31:0] er, rd;
        logic [6:0] occ;
        n  = (kind < 2) ? 1 : sz_bytes(sz);
        er = '0;
        if (kind == 0 || kind == 2) begin
            e = (ref_q.size() + n > 64);
            if (!e) for (int i = 0; i < n; i++) ref_q.push_back(wd[8*i +: 8]);
        end else begin
            e = (ref_q.size() < n);
            if (!e) for (int i = 0; i < n; i++) er[8*i +: 8] = ref_q.pop_front();
        end
        run_txn(kind, sz, wd, lat, err, rd, occ);
        check({tag, "_lat"}, lat, exp_lat(kind, n, e));
        check({tag, "_err"}, err, e);
        check({tag, "_occ"}, occ, ref_q.size());
        if (kind == 1 && !e) check({tag, "_usb_data"}, rd[7:0], er[7:0]);
        if (kind == 3)       check({tag, "_ahb_data"}, rd, er);
    endtask

    task automatic pair_test(input string tag, input logic [7:0] ub, input logic [7:0] ab, input logic ahb_first);
        int ku, ka;
        ku = -1; ka = -1;
        @(posedge clk); #1;
        usb_wr_data = ub; usb_wr_req = 1'b1;
        ahb_size = 2'd0; ahb_wr_data = {24'h0, ab}; ahb_wr_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (usb_wr_ack && ku < 0) ku = k;
            if (ahb_wr_ack && ka < 0) ka = k;
            @(posedge clk); #1;
            if (ku == k) usb_wr_req = 1'b0;
            if (ka == k) ahb_wr_req = 1'b0;
        end
        usb_wr_req = 1'b0; ahb_wr_req = 1'b0;
        check({tag, "_usb_ack_cycle"}, ku, ahb_first ? 4 : 2);
        check({tag, "_ahb_ack_cycle"}, ka, ahb_first ? 2 : 4);
        if (ahb_first) begin ref_q.push_back(ab); ref_q.push_back(ub); end
        else           begin ref_q.push_back(ub); ref_q.push_back(ab); end
        check({tag, "_occ"}, buffer_occupancy, ref_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [6:0]  occ;
        logic        saw_ack;

        tbl[0]  = '{0, 2'd0, 32'h0000_00A5, 1'b0, 32'h0,         7'd1};
        tbl[1]  = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_00A5, 7'd0};
        tbl[2]  = '{2, 2'd2, 32'hDDCC_BBAA, 1'b0, 32'h0,         7'd4};
        tbl[3]  = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_00AA, 7'd3};
        tbl[4]  = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_00BB, 7'd2};
        tbl[5]  = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_00CC, 7'd1};
        tbl[6]  = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_00DD, 7'd0};
        tbl[7]  = '{3, 2'd1, 32'h0,         1'b1, 32'h0,         7'd0};
        tbl[8]  = '{1, 2'd0, 32'h0,         1'b1, 32'h0,         7'd0};
        tbl[9]  = '{2, 2'd1, 32'h0000_1234, 1'b0, 32'h0,         7'd2};
        tbl[10] = '{3, 2'd0, 32'h0,         1'b0, 32'h0000_0034, 7'd1};
        tbl[11] = '{2, 2'd3, 32'h8765_4321, 1'b0, 32'h0,         7'd5};
        tbl[12] = '{3, 2'd2, 32'h0,         1'b0, 32'h6543_2112, 7'd1};
        tbl[13] = '{1, 2'd0, 32'h0,         1'b0, 32'h0000_0087, 7'd0};

        rst = 1'b1; clear = 1'b0;
        usb_wr_req = 1'b0; usb_wr_data = '0; usb_rd_req = 1'b0;
        ahb_wr_req = 1'b0; ahb_rd_req = 1'b0; ahb_size = '0; ahb_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_occupancy", buffer_occupancy, 0);
        check("reset_busy", busy, 0);
        check("reset_ack_err", {usb_wr_ack, usb_rd_ack, ahb_wr_ack, ahb_rd_ack, usb_err, ahb_err}, 0);
        check("reset_rd_data", {usb_rd_data, ahb_rd_data}, 0);
        check("reset_mem_port", {mem_addr, mem_wen, mem_ren, mem_wdata}, 0);

        for (int i = 0; i < 14; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_txn(tbl[i].kind, tbl[i].sz, tbl[i].wd, lat, err, rd, occ);
            check({t, "_lat"}, lat, exp_lat(tbl[i].kind, (tbl[i].kind < 2) ? 1 : sz_bytes(tbl[i].sz), tbl[i].exp_err));
            check({t, "_err"}, err, tbl[i].exp_err);
            check({t, "_occ"}, occ, tbl[i].exp_occ);
            if (tbl[i].kind == 1 && !tbl[i].exp_err) check({t, "_usb_data"}, rd[7:0], tbl[i].exp_rd[7:0]);
            if (tbl[i].kind == 3) check({t, "_ahb_data"}, rd, tbl[i].exp_rd);
        end

        // Fill to 64 across the pointer wrap, probe overflow, then drain in order.
        for (int i = 0; i < 16; i++) model_txn(2, 2'd2, $urandom, "fill");
        model_txn(2, 2'd0, 32'h5A, "full_ahb_wr");
        model_txn(0, 2'd0, 32'h5B, "full_usb_wr");
        for (int i = 0; i < 64; i++) model_txn(1, 2'd0, 32'h0, "drain");
        model_txn(1, 2'd0, 32'h0, "empty_usb_rd");

        pair_test("pair1", 8'h11, 8'h22, 1'b0);
`ifdef BUFFER_ARB_RR_EN
        pair_test("pair2", 8'h33, 8'h44, 1'b1);
`else
        pair_test("pair2", 8'h33, 8'h44, 1'b0);
`endif
        for (int i = 0; i < 4; i++) model_txn(1, 2'd0, 32'h0, "pair_drain");

        for (int i = 0; i < 3; i++) model_txn(0, 2'd0, 32'h60 + i, "pre_clear");
        saw_ack = 1'b0;
        @(posedge clk); #1;
        ahb_size = 2'd2; ahb_wr_data = 32'hF0F1_F2F3; ahb_wr_req = 1'b1;
        @(negedge clk); saw_ack |= ahb_wr_ack;
        @(posedge clk); #1;
        @(negedge clk); saw_ack |= ahb_wr_ack;
        @(posedge clk); #1 clear = 1'b1;
        @(negedge clk); saw_ack |= ahb_wr_ack;
        check("clear_inflight_occ", buffer_occupancy, 4);
        @(posedge clk); #1;
        clear = 1'b0; ahb_wr_req = 1'b0;
        @(negedge clk); saw_ack |= ahb_wr_ack;
        check("clear_occ", buffer_occupancy, 0);
        check("clear_busy", busy, 0);
        repeat (4) begin @(negedge clk); saw_ack |= ahb_wr_ack; end
        check("clear_no_ack", saw_ack, 0);
        ref_q.delete();
        model_txn(1, 2'd0, 32'h0, "after_clear_rd");

        for (int i = 0; i < 300; i++) begin
            model_txn($urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
